// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding and the
// default handshake timeout.
package uart_pkg;

    localparam int ACK_TIMEOUT_DEFAULT = 16;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        ISSUE     = ST_ISSUE,
        WAIT_BUSY = ST_WAIT_BUSY,
        WAIT_DONE = ST_WAIT_DONE
    } sched_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a 1-bit last-grant pointer. The pointer
// resets to channel 1 so that channel 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (update) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules single-byte (ch0) and two-byte (ch1) requests onto one UART TX,
// with round-robin arbitration, atomic words and a busy-handshake timeout.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    input  logic        cfg_par_en,
    input  logic        cfg_par_type,
    output logic        tx_par_en,
    output logic        tx_par_type,
    output logic        tx_data_vld,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        sched_busy,
    output logic        err_timeout
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    sched_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [7:0]    hi_q, hi_d;
    logic          second_q, second_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          par_en_q, par_en_d, par_type_q, par_type_d;
    logic          req0_ready_q, req0_ready_d, req1_ready_q, req1_ready_d;
    logic          vld_q, vld_d, busy_q, busy_d, err_q, err_d;
    logic [1:0]    grant;
    logic          do_grant;

    assign do_grant = (state_q == IDLE) && (req0_valid || req1_valid) && !tx_busy;
    assign cnt_inc  = cnt_q + CW'(1);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_valid, req0_valid}),
        .update (do_grant),
        .grant  (grant)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        second_d     = second_q;
        tx_data_d    = tx_data_q;
        par_en_d     = par_en_q;
        par_type_d   = par_type_q;
        req0_ready_d = 1'b0;
        req1_ready_d = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (do_grant) begin
                    state_d      = ISSUE;
                    par_en_d     = cfg_par_en;
                    par_type_d   = cfg_par_type;
                    second_d     = grant[1];
                    hi_d         = req1_data[15:8];
                    req0_ready_d = grant[0];
                    req1_ready_d = grant[1];
                    tx_data_d    = grant[0] ? req0_data : req1_data[7:0];
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
                cnt_d   = '0;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    // Abort drops any pending upper byte of a word.
                    if (cnt_inc == CW'(ACK_TIMEOUT)) begin
                        err_d    = 1'b1;
                        second_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (second_q) begin
                        state_d   = ISSUE;
                        tx_data_d = hi_q;
                        second_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        vld_d  = (state_d == ISSUE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q      <= IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            second_q     <= 1'b0;
            tx_data_q    <= '0;
            par_en_q     <= 1'b0;
            par_type_q   <= 1'b0;
            req0_ready_q <= 1'b0;
            req1_ready_q <= 1'b0;
            vld_q        <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            second_q     <= second_d;
            tx_data_q    <= tx_data_d;
            par_en_q     <= par_en_d;
            par_type_q   <= par_type_d;
            req0_ready_q <= req0_ready_d;
            req1_ready_q <= req1_ready_d;
            vld_q        <= vld_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign req0_ready  = req0_ready_q;
    assign req1_ready  = req1_ready_q;
    assign tx_par_en   = par_en_q;
    assign tx_par_type = par_type_q;
    assign tx_data_vld = vld_q;
    assign tx_data     = tx_data_q;
    assign sched_busy  = busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus randomized
// transactions compared against a transaction-level event model.
module tb_uart_tx_sched;

    localparam int TIMEOUT = 16;
    localparam logic [1:0] K_GRANT = 2'd0, K_STROBE = 2'd1, K_ERR = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] val;
        logic       pen;
        logic       ptype;
        logic       busy;
    } ev_t;

    logic        clk, rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0]  req0_data;
    logic [15:0] req1_data;
    logic        cfg_par_en, cfg_par_type, tx_par_en, tx_par_type;
    logic        tx_data_vld, sched_busy, err_timeout;
    logic [7:0]  tx_data;
    logic        tx_busy, busy_auto, busy_force;

    int  tests = 0;
    int  fails = 0;
    ev_t obs_q[$];
    ev_t exp_q[$];
    bit  resp_en;
    int  resp_dly, resp_hold;
    bit  model_last;

    assign tx_busy = busy_auto | busy_force;

    uart_tx_sched dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .cfg_par_en   (cfg_par_en),
        .cfg_par_type (cfg_par_type),
        .tx_par_en    (tx_par_en),
        .tx_par_type  (tx_par_type),
        .tx_data_vld  (tx_data_vld),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .sched_busy   (sched_busy),
        .err_timeout  (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1);
    end

    function automatic ev_t mk(input logic [1:0] k, input logic [7:0] v,
                               input logic pe, input logic pt, input logic b);
        ev_t e;
        e.kind = k; e.val = v; e.pen = pe; e.ptype = pt; e.busy = b;
        return e;
    endfunction

    // Event monitor: every grant, strobe and abort seen on the DUT boundary.
    always @(negedge clk) begin
        if (req0_ready)  obs_q.push_back(mk(K_GRANT, 8'd0, 1'b0, 1'b0, 1'b0));
        if (req1_ready)  obs_q.push_back(mk(K_GRANT, 8'd1, 1'b0, 1'b0, 1'b0));
        if (tx_data_vld) obs_q.push_back(mk(K_STROBE, tx_data, tx_par_en, tx_par_type, tx_busy));
        if (err_timeout) obs_q.push_back(mk(K_ERR, 8'd0, 1'b0, 1'b0, 1'b0));
    end

    // UART TX stand-in: busy rises resp_dly cycles after a strobe, stays resp_hold cycles.
    initial begin
        busy_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && tx_data_vld && rst) begin
                repeat (resp_dly) @(posedge clk);
                #2 busy_auto = 1'b1;
                repeat (resp_hold) @(posedge clk);
                #2 busy_auto = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req0_ready"}, req0_ready, 0);
        check({tag, "_req1_ready"}, req1_ready, 0);
        check({tag, "_tx_data_vld"}, tx_data_vld, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_tx_par_en"}, tx_par_en, 0);
        check({tag, "_tx_par_type"}, tx_par_type, 0);
        check({tag, "_sched_busy"}, sched_busy, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
    endtask

    task automatic wait_busy(input logic val, input string tag);
        int n = 0;
        while (tx_busy !== val && n < 100) begin
            tick();
            n++;
        end
        check(tag, tx_busy, val);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((sched_busy || tx_busy) && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, n < 400, 1);
        repeat (2) tick();
    endtask

    // Raise the masked requests and hold each until its ready pulse; then scramble its data.
    task automatic grab(input logic [1:0] mask, input logic [7:0] d0, input logic [15:0] d1,
                        input string tag);
        logic [1:0] seen = 2'b00;
        int n = 0;
        req0_data  = d0;
        req1_data  = d1;
        req0_valid = mask[0];
        req1_valid = mask[1];
        while (seen != mask && n < 600) begin
            tick();
            n++;
            if (req0_ready) begin seen[0] = 1'b1; req0_valid = 1'b0; req0_data = ~d0; end
            if (req1_ready) begin seen[1] = 1'b1; req1_valid = 1'b0; req1_data = ~d1; end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({tag, "_granted"}, seen, mask);
    endtask

    task automatic send(input logic [1:0] mask, input logic [7:0] d0, input logic [15:0] d1,
                        input string tag);
        grab(mask, d0, d1, tag);
        wait_idle(tag);
    endtask

    // Reference model: one granted transaction as the sequence of boundary events.
    task automatic model_txn(input bit ch, input logic [7:0] d0, input logic [15:0] d1,
                             input logic pen, input logic ptype, input bit full);
        exp_q.push_back(mk(K_GRANT, {7'd0, ch}, 1'b0, 1'b0, 1'b0));
        if (!ch) begin
            exp_q.push_back(mk(K_STROBE, d0, pen, ptype, 1'b0));
        end else begin
            exp_q.push_back(mk(K_STROBE, d1[7:0], pen, ptype, 1'b0));
            if (full) exp_q.push_back(mk(K_STROBE, d1[15:8], pen, ptype, 1'b0));
        end
        model_last = ch;
    endtask

    task automatic model_send(input logic [1:0] mask, input logic [7:0] d0, input logic [15:0] d1,
                              input logic pen, input logic ptype);
        bit first;
        if (mask == 2'b11) begin
            first = ~model_last;
            model_txn(first, d0, d1, pen, ptype, 1'b1);
            model_txn(~first, d0, d1, pen, ptype, 1'b1);
        end else begin
            model_txn(mask[1], d0, d1, pen, ptype, 1'b1);
        end
    endtask

    task automatic compare_logs(input string tag);
        check({tag, "_events"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0]  r0;
        logic [15:0] w;
        logic [3:0]  gord;
        logic [31:0] bytes;
        int          gi, si, cnt, n;
        logic        early, pen0, pt0;
        logic [1:0]  mask;

        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        cfg_par_en = 1'b0; cfg_par_type = 1'b0;
        busy_force = 1'b0;
        resp_en = 1'b1; resp_dly = 1; resp_hold = 12;
        model_last = 1'b1;

        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Single byte, busy rises one cycle after strobe, high 12 cycles.
        grab(2'b01, 8'hA5, 16'h0, "t034");
        wait_busy(1'b1, "t034_busy_rise");
        wait_busy(1'b0, "t034_busy_fall");
        tick();
        check("t034_sched_idle", sched_busy, 0);
        check("t034_data_hold", tx_data, 8'hA5);
        model_txn(1'b0, 8'hA5, 16'h0, 1'b0, 1'b0, 1'b1);
        compare_logs("t034");

        // Word LSB first; ch0 raised mid-word waits for the word to finish.
        cfg_par_type = 1'b1;
        grab(2'b10, 8'h00, 16'h1234, "t035");
        r0 = 8'($urandom);
        req0_data = r0;
        req0_valid = 1'b1;
        n = 0;
        while (!req0_ready && n < 600) begin tick(); n++; end
        req0_valid = 1'b0;
        check("t035_ch0_granted", req0_ready, 1);
        wait_idle("t035");
        model_txn(1'b1, 8'h00, 16'h1234, 1'b0, 1'b1, 1'b1);
        model_txn(1'b0, r0, 16'h0, 1'b0, 1'b1, 1'b1);
        compare_logs("t035");

        // External busy in IDLE blocks grants; a withdrawn request is never granted.
        busy_force = 1'b1;
        req1_data = 16'($urandom);
        req1_valid = 1'b1;
        repeat (4) tick();
        req1_valid = 1'b0;
        r0 = 8'($urandom);
        req0_data = r0;
        req0_valid = 1'b1;
        repeat (6) tick();
        check("t027_no_grant_while_busy", obs_q.size(), 0);
        busy_force = 1'b0;
        n = 0;
        while (!req0_ready && n < 50) begin tick(); n++; end
        req0_valid = 1'b0;
        check("t027_grant_after_busy", req0_ready, 1);
        wait_idle("t027");
        model_txn(1'b0, r0, 16'h0, 1'b0, 1'b1, 1'b1);
        compare_logs("t027");

        // Both valid continuously from reset: strict alternation starting with ch0.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_last = 1'b1;
        cfg_par_type = 1'b0;
        tick();
        req0_data = 8'h11;
        req1_data = 16'h2233;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        cnt = 0;
        n = 0;
        while (cnt < 4 && n < 1000) begin
            tick();
            n++;
            if (req0_ready || req1_ready) cnt++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("t036_four_grants", cnt, 4);
        wait_idle("t036");
        gord = '0; bytes = '0; gi = 0; si = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i].kind == K_GRANT && gi < 4) begin gord[gi] = obs_q[i].val[0]; gi++; end
            if (obs_q[i].kind == K_STROBE && si < 4) begin bytes = {bytes[23:0], obs_q[i].val}; si++; end
        end
        check("t036_grant_order", gord, 4'b1010);
        check("t036_byte_order", bytes, 32'h11332211);
        for (int i = 0; i < 4; i++) model_txn(~model_last, 8'h11, 16'h2233, 1'b0, 1'b0, 1'b1);
        compare_logs("t036");

        // No busy response: abort exactly TIMEOUT cycles into WAIT_BUSY, upper byte dropped.
        resp_en = 1'b0;
        w = 16'($urandom);
        grab(2'b10, 8'h00, w, "t037");
        check("t037_strobe", tx_data_vld, 1);
        early = 1'b0;
        for (int j = 1; j <= TIMEOUT; j++) begin
            tick();
            early = early | err_timeout;
        end
        check("t037_no_early_err", early, 0);
        tick();
        check("t037_err_pulse", err_timeout, 1);
        check("t037_back_idle", sched_busy, 0);
        tick();
        check("t037_err_one_cycle", err_timeout, 0);
        repeat (30) tick();
        model_txn(1'b1, 8'h00, w, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(mk(K_ERR, 8'd0, 1'b0, 1'b0, 1'b0));
        compare_logs("t037");
        resp_en = 1'b1;

        // Parity config change mid-word is ignored until the next grant.
        cfg_par_en = 1'b0;
        pt0 = 1'($urandom);
        cfg_par_type = pt0;
        w = 16'($urandom);
        grab(2'b10, 8'h00, w, "t038");
        cfg_par_en = 1'b1;
        cfg_par_type = ~pt0;
        wait_idle("t038");
        model_txn(1'b1, 8'h00, w, 1'b0, pt0, 1'b1);
        r0 = 8'($urandom);
        send(2'b01, r0, 16'h0, "t038b");
        model_txn(1'b0, r0, 16'h0, 1'b1, ~pt0, 1'b1);
        compare_logs("t038");

        // Asynchronous reset during WAIT_DONE of the first word byte.
        cfg_par_en = 1'b0;
        cfg_par_type = 1'b0;
        grab(2'b10, 8'h00, 16'h1234, "t039");
        wait_busy(1'b1, "t039_busy_rise");
        tick();
        #1 rst = 1'b0;
        #1 check_reset_outputs("t039_async");
        tick();
        tick();
        rst = 1'b1;
        model_last = 1'b1;
        repeat (40) tick();
        check_reset_outputs("t039_after");
        model_txn(1'b1, 8'h00, 16'h1234, 1'b0, 1'b0, 1'b0);
        compare_logs("t039");

        // Randomized transactions against the model.
        for (int k = 0; k < 16; k++) begin
            mask = 2'($urandom_range(1, 3));
            r0 = 8'($urandom);
            w = 16'($urandom);
            pen0 = 1'($urandom);
            pt0 = 1'($urandom);
            cfg_par_en = pen0;
            cfg_par_type = pt0;
            resp_dly = $urandom_range(1, 6);
            resp_hold = $urandom_range(1, 10);
            send(mask, r0, w, $sformatf("rnd%0d", k));
            model_send(mask, r0, w, pen0, pt0);
            compare_logs($sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16: max cycles to wait for tx_busy rise after an issue.
REQ-002 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req0_valid  input  1  channel 0 (single byte) request.
REQ-005 SHALL have port req0_data  input  8  channel 0 byte.
REQ-006 SHALL have port req0_ready  output  1  one-cycle accept pulse, channel 0.
REQ-007 SHALL have port req1_valid  input  1  channel 1 (two-byte word) request.
REQ-008 SHALL have port req1_data  input  16  channel 1 word, sent LSB byte first.
REQ-009 SHALL have port req1_ready  output  1  one-cycle accept pulse, channel 1.
REQ-010 SHALL have ports cfg_par_en, cfg_par_type  input  1 each  requested parity config.
REQ-011 SHALL have ports tx_par_en, tx_par_type  output  1 each  parity config driven to UART TX.
REQ-012 SHALL have port tx_data_vld  output  1  byte-valid strobe to UART TX.
REQ-013 SHALL have port tx_data  output  8  byte to UART TX.
REQ-014 SHALL have port tx_busy  input  1  UART TX busy.
REQ-015 SHALL have port sched_busy  output  1  high whenever state != IDLE.
REQ-016 SHALL have port err_timeout  output  1  one-cycle pulse on transaction abort.

Function
REQ-017 States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-018 IDLE: grant only when (req0_valid|req1_valid) and tx_busy=0; on grant, pulse the granted reqN_ready for exactly one cycle, capture data, byte count (1 or 2) and cfg_par_* -> go ISSUE.
REQ-019 Arbitration: round-robin with 1-bit last-grant pointer; both valid -> grant the channel not last granted; single valid -> grant it; pointer resets to 1 so channel 0 wins the first tie.
REQ-020 ISSUE: tx_data_vld=1 for exactly one cycle with tx_data = current byte (req0 byte, or req1 [7:0] then [15:8]) -> WAIT_BUSY.
REQ-021 WAIT_BUSY: on tx_busy=1 -> WAIT_DONE; timeout counter increments each cycle; counter reaching ACK_TIMEOUT with tx_busy still 0 -> pulse err_timeout, drop the rest of the transaction, -> IDLE.
REQ-022 WAIT_DONE: on tx_busy=0 -> ISSUE if a second byte remains, else IDLE.
REQ-023 Channel-1 word SHALL be atomic: no grant to channel 0 between its two bytes.
REQ-024 tx_par_en/tx_par_type SHALL update only at grant and hold constant until return to IDLE; cfg changes mid-transaction are ignored.
REQ-025 tx_data SHALL hold its value outside ISSUE (no glitch to 0).
REQ-026 Request withdrawn (valid drop) before grant: no ready, no issue; data after ready pulse is ignored (captured copy used).
REQ-027 tx_busy=1 in IDLE (external frame in flight): no grant until tx_busy=0.
REQ-028 Timeout counter width = clog2(ACK_TIMEOUT+1); cleared on entry to WAIT_BUSY.
REQ-029 Minimum spacing: one grant per transaction; a new grant is possible in the cycle after returning to IDLE.

Reset
REQ-030 rst=0 SHALL asynchronously force state IDLE, pointer=1, counter=0, and outputs req0_ready=0, req1_ready=0, tx_data_vld=0, tx_data=0, tx_par_en=0, tx_par_type=0, sched_busy=0, err_timeout=0.
REQ-031 Reset mid-transaction SHALL discard captured data with no ready, strobe or error afterwards.

Structure
REQ-032 State encoding localparams and ACK_TIMEOUT default SHALL live in shared package uart_pkg.
REQ-033 The two-way round-robin grant logic SHALL be sub-module rr_arb2 (inputs req[1:0], update; output grant[1:0]).

Verification
REQ-034 req0_valid with 0xA5, tx_busy model rising 1 cycle after strobe, 12 cycles high -> req0_ready pulse, one strobe with tx_data=0xA5, sched_busy low after busy falls.
REQ-035 req1_valid with 0x1234 -> strobes with 0x34 then 0x12, second strobe only after tx_busy falls; req0 raised mid-word not granted until word done.
REQ-036 Both valid continuously (0x11, 0x2233) -> grant order ch0, ch1, ch0, ch1; bytes 0x11, 0x33, 0x22, 0x11.
REQ-037 tx_busy held 0 after strobe, ACK_TIMEOUT=16 -> err_timeout pulse 16 cycles after entering WAIT_BUSY, state IDLE, no second strobe for req1.
REQ-038 cfg_par_en toggled 0->1 during req1 word -> tx_par_en stays 0 for both bytes, becomes 1 at next grant.
REQ-039 rst asserted in WAIT_DONE of req1 first byte -> all outputs at reset values, no 0x12 strobe after release.
